slices_bitserial_mac: RTL and testbench
=======================================

Name: slices_bitserial_mac

Overview:
Multi-bit successor to the binary-input slice array. N parallel channels each compute a dot product of an LEN-element activation vector with that channel's LEN x W_BITS weights. Activations have A_BITS bits and arrive bit-serially, one LEN-bit plane per handshake, MSB plane first; each channel shift-accumulates the per-plane partial sums. Sits between the activation bit-plane streamer and the Q result consumer, with valid/ready on both sides.

Parameters:
N, 64, channel count
LEN, 256, activation elements per plane (plane width)
W_BITS, 4, bits per weight
A_BITS, 4, activation bits = planes per operation (>=1)
Q_W, 20, per-channel result width; result wraps modulo 2^Q_W

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
plane_in  in  LEN  one activation bit-plane; bit j = bit of element j
plane_valid  in  1  plane_in valid
plane_ready  out  1  block accepts a plane this cycle
weight_arrays_flat  in  N*LEN*W_BITS  channel c, element j weight at [(c*LEN+j)*W_BITS +: W_BITS]; must stay stable from first plane accept until q handshake
Q_total_flat  out  N*Q_W  channel c result at [c*Q_W +: Q_W]
q_valid  out  1  Q_total_flat holds a complete result
q_ready  in  1  consumer accepts result
busy  out  1  at least one plane of the current operation accepted, result not yet valid

Behaviour:
- Reset values: plane_ready=0, q_valid=0, busy=0, Q_total_flat=0, plane counter=0, state=IDLE.
- States: IDLE -> ACCUM unconditionally on first clk edge after reset release. ACCUM -> DONE on accepting plane with counter==A_BITS-1. DONE -> ACCUM on q_valid&&q_ready.
- plane_ready = (state==ACCUM); q_valid = (state==DONE); busy = (state==ACCUM && counter!=0).
- Plane accept = plane_valid && plane_ready. Per accept, per channel: partial = sum over j of (plane_in[j] ? w[c][j] : 0), computed combinationally, width >= ceil(log2(LEN*(2^W_BITS-1)+1)).
- Accumulate: counter==0 -> acc = partial; otherwise acc = (acc<<1) + partial; all mod 2^Q_W. counter increments, wraps to 0 after A_BITS-1.
- Latency: final plane accepted on edge t -> q_valid=1 and Q valid after edge t; no further pipeline stage.
- Q_total_flat equals acc and is held stable throughout DONE; it remains unchanged after the q handshake until the next accept overwrites it.
- plane_ready=0 in DONE: one bubble minimum between operations. With q_ready held high, DONE lasts exactly one cycle.
- plane_valid low in ACCUM: no state change; a partial operation waits indefinitely.
- Reset asserted mid-operation or in DONE: immediate return to reset values; the partial result is discarded; the next operation starts at counter=0.
- Unsigned arithmetic throughout (default build).

Optional Feature:
Macro SLICES_SIGNED_W_EN. Defined: weights are two's complement W_BITS values, sign-extended before summation; partial and acc are signed; Q_total_flat is two's complement Q_W bits (wrap, no saturation). Activations remain unsigned. Undefined: weights are unsigned as above.

Test Plan:
- Defaults, all planes all-ones (activation 15), weights ch0=4'h1, ch1=4'h2, ch2=4'h3, others 0, q_ready=1 -> Q0=3840, Q1=7680, Q2=11520, Q3..Q63=0; q_valid high 1 cycle after the 4th plane accept.
- Planes MSB-first 1s,0s,0s,0s (activation 8), ch0 weights 4'h1 -> Q0=2048; with ch0 weights 4'hF -> Q0=30720.
- Hold q_ready=0 for 5 cycles after result -> q_valid and Q stable; plane_ready=0; planes presented are not accepted; after q_ready=1, plane_ready=1 on the next cycle.
- Assert reset after 2 of 4 planes accepted, then run a full all-ones op with ch0=1 -> busy/q_valid drop immediately; result Q0=3840, uncorrupted by the aborted planes.
- plane_valid toggled 1/0 every cycle -> same result as a contiguous stream; counter advances only on accepts.
- SLICES_SIGNED_W_EN defined, ch0 weights 4'hF (-1), all-ones activation -> Q0=20'hFF100 (-3840); undefined -> Q0=57600.

Source files
------------

// File: rtl/slices_bitserial_mac.sv
// slices_bitserial_mac: N-channel bit-serial dot-product engine.
// Each accepted LEN-bit activation plane (MSB plane first) is reduced against
// the per-channel weights and shift-accumulated into a Q_W-bit result per
// channel. After A_BITS planes the result is offered on a valid/ready port.
// Optional build macro SLICES_SIGNED_W_EN: weights are two's complement and
// the accumulation is signed (results wrap modulo 2^Q_W, no saturation).
module slices_bitserial_mac #(
  parameter int unsigned N      = 64,
  parameter int unsigned LEN    = 256,
  parameter int unsigned W_BITS = 4,
  parameter int unsigned A_BITS = 4,
  parameter int unsigned Q_W    = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LEN-1:0]             plane_in,
  input  logic                       plane_valid,
  output logic                       plane_ready,
  input  logic [N*LEN*W_BITS-1:0]    weight_arrays_flat,
  output logic [N*Q_W-1:0]           Q_total_flat,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic                       busy
);

  // Unsigned per-plane partial needs PW_U bits; one extra covers the signed build.
  localparam int unsigned PW_U = $clog2(LEN * ((1 << W_BITS) - 1) + 1);
  localparam int unsigned PW   = PW_U + 1;
  // Summing at least Q_W bits wide keeps the low Q_W bits exact modulo 2^Q_W.
  localparam int unsigned SW   = (PW > Q_W) ? PW : Q_W;
  localparam int unsigned CW   = (A_BITS > 1) ? $clog2(A_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(A_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          plane_ready_q;
  logic          q_valid_q;
  logic          busy_q;
  logic          accept;

  assign accept      = plane_valid && plane_ready_q;
  assign plane_ready = plane_ready_q;
  assign q_valid     = q_valid_q;
  assign busy        = busy_q;

  // Control FSM: plane counter plus registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      plane_ready_q <= 1'b0;
      q_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q       <= ST_ACCUM;
          plane_ready_q <= 1'b1;
          q_valid_q     <= 1'b0;
          busy_q        <= 1'b0;
        end
        ST_ACCUM: begin
          if (plane_valid) begin
            if (cnt_q == CNT_LAST) begin
              state_q       <= ST_DONE;
              cnt_q         <= '0;
              plane_ready_q <= 1'b0;
              q_valid_q     <= 1'b1;
              busy_q        <= 1'b0;
            end else begin
              cnt_q  <= cnt_q + CW'(1);
              busy_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (q_ready) begin
            state_q       <= ST_ACCUM;
            plane_ready_q <= 1'b1;
            q_valid_q     <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          cnt_q         <= '0;
          plane_ready_q <= 1'b0;
          q_valid_q     <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [SW-1:0]     sum_c;
    logic [W_BITS-1:0] w_c;
    logic [Q_W-1:0]    acc_q;
    logic [Q_W-1:0]    acc_d;

    // Per-plane partial: sum of this channel's weights where the plane bit is set.
    always_comb begin
      sum_c = '0;
      w_c   = '0;
      for (int j = 0; j < LEN; j++) begin
        w_c = weight_arrays_flat[(c*LEN + j)*W_BITS +: W_BITS];
        if (plane_in[j]) begin
`ifdef SLICES_SIGNED_W_EN
          sum_c = sum_c + SW'($signed(w_c));
`else
          sum_c = sum_c + SW'(w_c);
`endif
        end
      end
    end

    // Shift-accumulate: first plane of an operation restarts the accumulator.
    always_comb begin
      acc_d = (cnt_q == '0) ? sum_c[Q_W-1:0]
                            : (acc_q << 1) + sum_c[Q_W-1:0];
    end

    // Accumulator register doubles as the held result while in DONE.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc_q <= '0;
      end else if (accept) begin
        acc_q <= acc_d;
      end
    end

    assign Q_total_flat[c*Q_W +: Q_W] = acc_q;
  end

endmodule

// File: tb/tb_slices_bitserial_mac.sv
// Directed bench for slices_bitserial_mac: a result scoreboard fed by the
// stimulus and drained by a monitor on each q handshake, plus inline checks
// of handshake/status timing.
module tb_slices_bitserial_mac;

  localparam int unsigned N      = 64;
  localparam int unsigned LEN    = 256;
  localparam int unsigned W_BITS = 4;
  localparam int unsigned A_BITS = 4;
  localparam int unsigned Q_W    = 20;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LEN-1:0]          plane_in;
  logic                    plane_valid;
  logic                    plane_ready;
  logic [N*LEN*W_BITS-1:0] w_flat;
  logic [N*Q_W-1:0]        Q_total_flat;
  logic                    q_valid;
  logic                    q_ready;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  logic [N*Q_W-1:0] exp_q[$];
  logic [N*Q_W-1:0] mon_exp;

  logic [LEN-1:0] ones;
  logic [LEN-1:0] zero;

  slices_bitserial_mac #(
    .N(N), .LEN(LEN), .W_BITS(W_BITS), .A_BITS(A_BITS), .Q_W(Q_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .plane_in          (plane_in),
    .plane_valid       (plane_valid),
    .plane_ready       (plane_ready),
    .weight_arrays_flat(w_flat),
    .Q_total_flat      (Q_total_flat),
    .q_valid           (q_valid),
    .q_ready           (q_ready),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_w(input int c, input logic [W_BITS-1:0] v);
    for (int j = 0; j < LEN; j++) w_flat[(c*LEN + j)*W_BITS +: W_BITS] = v;
  endtask

  task automatic push_exp(input logic [Q_W-1:0] q0, input logic [Q_W-1:0] q1,
                          input logic [Q_W-1:0] q2);
    logic [N*Q_W-1:0] e;
    e = '0;
    e[0*Q_W +: Q_W] = q0;
    e[1*Q_W +: Q_W] = q1;
    e[2*Q_W +: Q_W] = q2;
    exp_q.push_back(e);
  endtask

  // Present one plane and hold it until the cycle in which it is accepted.
  task automatic send_plane(input logic [LEN-1:0] p);
    int n;
    n = 0;
    plane_in    = p;
    plane_valid = 1'b1;
    while (!plane_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL plane_accept_timeout: plane_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk); #1;
    plane_valid = 1'b0;
  endtask

  // Send A_BITS planes MSB first; optionally leave an idle cycle between planes.
  task automatic run_op(input logic [LEN-1:0] p0, input logic [LEN-1:0] p1,
                        input logic [LEN-1:0] p2, input logic [LEN-1:0] p3,
                        input bit gap);
    logic [LEN-1:0] pl[4];
    pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3;
    for (int k = 0; k < 4; k++) begin
      send_plane(pl[k]);
      if (k < 3) begin
        chk("busy_mid_op", 32'(busy), 32'd1);
        if (gap) begin
          @(posedge clk); #1;
          chk("busy_in_gap", 32'(busy), 32'd1);
        end
      end
    end
    chk("q_valid_after_last_plane", 32'(q_valid), 32'd1);
    chk("plane_ready_in_done", 32'(plane_ready), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
  endtask

  // With q_ready high the DONE state lasts one cycle.
  task automatic after_done();
    @(posedge clk); #1;
    chk("q_valid_drop", 32'(q_valid), 32'd0);
    chk("plane_ready_back", 32'(plane_ready), 32'd1);
  endtask

  // Result monitor: compare the full result vector on every q handshake.
  always @(negedge clk) begin
    if (!reset && q_valid && q_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: q handshake with no expected result, Q0=%0d",
                 Q_total_flat[Q_W-1:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (Q_total_flat !== mon_exp) begin
          failures++;
          for (int c = 0; c < int'(N); c++) begin
            if (Q_total_flat[c*Q_W +: Q_W] !== mon_exp[c*Q_W +: Q_W]) begin
              $display("FAIL result ch%0d: got %0d (0x%0h) expected %0d (0x%0h)", c,
                       Q_total_flat[c*Q_W +: Q_W], Q_total_flat[c*Q_W +: Q_W],
                       mon_exp[c*Q_W +: Q_W], mon_exp[c*Q_W +: Q_W]);
              break;
            end
          end
        end
      end
    end
  end

  initial begin
    ones        = '1;
    zero        = '0;
    reset       = 1'b1;
    plane_in    = '0;
    plane_valid = 1'b0;
    q_ready     = 1'b1;
    w_flat      = '0;

    // Reset values
    #1;
    chk("reset_plane_ready", 32'(plane_ready), 32'd0);
    chk("reset_q_valid", 32'(q_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_q_zero", 32'(Q_total_flat == '0), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_to_accum", 32'(plane_ready), 32'd1);

    // All-ones activation (15) against weights 1/2/3 on channels 0..2
    set_w(0, 4'h1); set_w(1, 4'h2); set_w(2, 4'h3);
    push_exp(20'd3840, 20'd7680, 20'd11520);
    run_op(ones, ones, ones, ones, 1'b0);
    after_done();

    // Activation 8 (MSB plane only), weights 1 then 15 on channel 0
    w_flat = '0;
    set_w(0, 4'h1);
    push_exp(20'd2048, 20'd0, 20'd0);
    run_op(ones, zero, zero, zero, 1'b0);
    after_done();
    set_w(0, 4'hF);
`ifdef SLICES_SIGNED_W_EN
    push_exp(20'hFF800, 20'd0, 20'd0);
`else
    push_exp(20'd30720, 20'd0, 20'd0);
`endif
    run_op(ones, zero, zero, zero, 1'b0);
    after_done();

    // Consumer stall: result held, planes refused while q_ready is low
    set_w(0, 4'h1);
    q_ready = 1'b0;
    push_exp(20'd3840, 20'd0, 20'd0);
    run_op(ones, ones, ones, ones, 1'b0);
    plane_in    = ones;
    plane_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_q_valid", 32'(q_valid), 32'd1);
      chk("stall_q0", 32'(Q_total_flat[Q_W-1:0]), 32'd3840);
      chk("stall_plane_ready", 32'(plane_ready), 32'd0);
    end
    q_ready     = 1'b1;
    plane_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_stall_plane_ready", 32'(plane_ready), 32'd1);
    chk("post_stall_q_valid", 32'(q_valid), 32'd0);
    chk("post_stall_busy", 32'(busy), 32'd0);
    chk("post_stall_q0_held", 32'(Q_total_flat[Q_W-1:0]), 32'd3840);
    push_exp(20'd2048, 20'd0, 20'd0);
    run_op(ones, zero, zero, zero, 1'b0);
    after_done();

    // Reset mid-operation discards the partial accumulation
    send_plane(ones);
    send_plane(ones);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q_valid", 32'(q_valid), 32'd0);
    chk("abort_plane_ready", 32'(plane_ready), 32'd0);
    chk("abort_q0_cleared", 32'(Q_total_flat[Q_W-1:0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    push_exp(20'd3840, 20'd0, 20'd0);
    run_op(ones, ones, ones, ones, 1'b0);
    after_done();

    // Toggled plane_valid, activation 11 (planes 1,0,1,1), weights 1 and 2
    set_w(1, 4'h2);
    push_exp(20'd2816, 20'd5632, 20'd0);
    run_op(ones, zero, ones, ones, 1'b1);
    after_done();

    // Weight 4'hF alone: -1 in the signed build, 15 otherwise
    w_flat = '0;
    set_w(0, 4'hF);
`ifdef SLICES_SIGNED_W_EN
    push_exp(20'hFF100, 20'd0, 20'd0);
`else
    push_exp(20'd57600, 20'd0, 20'd0);
`endif
    run_op(ones, ones, ones, ones, 1'b0);
    after_done();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
